// File: rtl/pipe_stage_reg_if.sv
// Handshake and status bundle for one pipeline stage boundary.
// The master modport faces the upstream/downstream driver; the slave modport faces the stage register.
interface pipe_stage_reg_if #(
   parameter int unsigned WIDTH  = 128,
   parameter int unsigned CTRL_W = 16,
   parameter int unsigned CNT_W  = 8
) ();

   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  out_data;
   logic [CTRL_W-1:0] out_ctrl;
   logic              stall;
   logic              flush;
   logic [1:0]        occ;
   logic [CNT_W-1:0]  drop_cnt;

   modport master (
      output in_valid, in_data, in_ctrl, out_ready, stall, flush,
      input  in_ready, out_valid, out_data, out_ctrl, occ, drop_cnt
   );

   modport slave (
      input  in_valid, in_data, in_ctrl, out_ready, stall, flush,
      output in_ready, out_valid, out_data, out_ctrl, occ, drop_cnt
   );

endinterface

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with optional skid entry, legacy stall/flush,
// and a saturating count of entries squashed by flush.
module pipe_stage_reg #(
   parameter int unsigned WIDTH  = 128,
   parameter int unsigned CTRL_W = 16,
   parameter int unsigned SKID   = 1,
   parameter int unsigned CNT_W  = 8
) (
   input  logic                  CLK,
   input  logic                  nRST,
   pipe_stage_reg_if.slave       bus
);

   localparam int unsigned SUM_W = CNT_W + 2;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic              main_v_q,    main_v_d;
   logic              skid_v_q,    skid_v_d;
   logic [WIDTH-1:0]  main_data_q, main_data_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [WIDTH-1:0]  skid_data_q, skid_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic [CNT_W-1:0]  drop_cnt_q,  drop_cnt_d;

   logic              in_ready_c;
   logic              out_valid_c;
   logic              in_f;
   logic              out_f;
   logic [1:0]        drop_n;
   logic [SUM_W-1:0]  drop_sum;

   // Skid variant breaks the ready path; single-entry variant passes out_ready through.
   always_comb begin
      in_ready_c = 1'b0;
      if (SKID != 0) begin
         in_ready_c = ~skid_v_q & ~bus.stall;
      end else begin
         in_ready_c = (~main_v_q | bus.out_ready) & ~bus.stall;
      end
   end

   assign out_valid_c = main_v_q & ~bus.stall;
   assign in_f        = bus.in_valid & in_ready_c;
   assign out_f       = out_valid_c & bus.out_ready;

   // Entries held but not consumed this cycle; out_f can only retire the main entry.
   assign drop_n   = {1'b0, main_v_q} + {1'b0, skid_v_q} - {1'b0, out_f};
   assign drop_sum = SUM_W'(drop_cnt_q) + SUM_W'(drop_n);

   always_comb begin
      main_v_d    = main_v_q;
      skid_v_d    = skid_v_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
      drop_cnt_d  = drop_cnt_q;

      if (bus.flush) begin
         // Payload is left in place so out_data keeps its last value.
         main_v_d   = 1'b0;
         skid_v_d   = 1'b0;
         drop_cnt_d = (drop_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : drop_sum[CNT_W-1:0];
      end else if (!bus.stall) begin
         if (SKID != 0) begin
            if (out_f) begin
               if (skid_v_q) begin
                  main_data_d = skid_data_q;
                  main_ctrl_d = skid_ctrl_q;
                  skid_v_d    = 1'b0;
               end else if (in_f) begin
                  main_data_d = bus.in_data;
                  main_ctrl_d = bus.in_ctrl;
               end else begin
                  main_v_d = 1'b0;
               end
            end else if (in_f) begin
               if (main_v_q) begin
                  skid_data_d = bus.in_data;
                  skid_ctrl_d = bus.in_ctrl;
                  skid_v_d    = 1'b1;
               end else begin
                  main_data_d = bus.in_data;
                  main_ctrl_d = bus.in_ctrl;
                  main_v_d    = 1'b1;
               end
            end
         end else begin
            if (in_f) begin
               main_data_d = bus.in_data;
               main_ctrl_d = bus.in_ctrl;
            end
            main_v_d = in_f | (main_v_q & ~out_f);
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         main_v_q    <= 1'b0;
         skid_v_q    <= 1'b0;
         main_data_q <= '0;
         main_ctrl_q <= '0;
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         main_v_q    <= main_v_d;
         skid_v_q    <= skid_v_d;
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.out_data  = main_data_q;
   assign bus.out_ctrl  = main_ctrl_q & {CTRL_W{out_valid_c}};
   assign bus.occ       = {1'b0, main_v_q} + {1'b0, skid_v_q};
   assign bus.drop_cnt  = drop_cnt_q;

   // The skid entry is only ever filled behind an occupied main entry.
   a_skid_implies_main: assert property (@(posedge CLK) disable iff (!nRST) skid_v_q |-> main_v_q);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a skid instance and a single-entry instance side by side.
module tb_pipe_stage_reg;

   localparam int unsigned WIDTH  = 32;
   localparam int unsigned CTRL_W = 8;
   localparam int unsigned CNT_W  = 8;

   logic CLK;
   logic nRST;

   int n_tests;
   int n_fail;

   pipe_stage_reg_if #(.WIDTH(WIDTH), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) s ();
   pipe_stage_reg_if #(.WIDTH(WIDTH), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) n ();

   pipe_stage_reg #(.WIDTH(WIDTH), .CTRL_W(CTRL_W), .SKID(1), .CNT_W(CNT_W)) u_skid (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (s)
   );

   pipe_stage_reg #(.WIDTH(WIDTH), .CTRL_W(CTRL_W), .SKID(0), .CNT_W(CNT_W)) u_noskid (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (n)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drv_s(input logic v, input logic [31:0] d, input logic [7:0] c);
      s.in_valid = v;
      s.in_data  = d;
      s.in_ctrl  = c;
   endtask

   task automatic drv_n(input logic v, input logic [31:0] d, input logic [7:0] c);
      n.in_valid = v;
      n.in_data  = d;
      n.in_ctrl  = c;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      nRST    = 1'b0;
      drv_s(1'b0, 32'h0, 8'h0);
      drv_n(1'b0, 32'h0, 8'h0);
      s.out_ready = 1'b0; s.stall = 1'b0; s.flush = 1'b0;
      n.out_ready = 1'b0; n.stall = 1'b0; n.flush = 1'b0;

      // Reset state
      #2;
      chk("rst_occ",       32'(s.occ),       32'h0);
      chk("rst_out_valid", 32'(s.out_valid), 32'h0);
      chk("rst_out_data",  32'(s.out_data),  32'h0);
      chk("rst_out_ctrl",  32'(s.out_ctrl),  32'h0);
      chk("rst_drop_cnt",  32'(s.drop_cnt),  32'h0);
      chk("rst_in_ready",  32'(s.in_ready),  32'h1);
      #10;
      nRST = 1'b1;
      tick();

      // 1) Streaming with out_ready=1: one-cycle latency, occ stays 1
      s.out_ready = 1'b1;
      drv_s(1'b1, 32'h1, 8'h11);
      settle();
      chk("t1_in_ready", 32'(s.in_ready), 32'h1);
      tick();
      chk("t1_data1", 32'(s.out_data),  32'h1);
      chk("t1_vld1",  32'(s.out_valid), 32'h1);
      chk("t1_occ1",  32'(s.occ),       32'h1);
      drv_s(1'b1, 32'h2, 8'h12);
      tick();
      chk("t1_data2", 32'(s.out_data), 32'h2);
      chk("t1_occ2",  32'(s.occ),      32'h1);
      drv_s(1'b1, 32'h3, 8'h13);
      tick();
      chk("t1_data3", 32'(s.out_data), 32'h3);
      chk("t1_ctrl3", 32'(s.out_ctrl), 32'h13);
      chk("t1_occ3",  32'(s.occ),      32'h1);
      drv_s(1'b0, 32'h0, 8'h0);
      tick();
      chk("t1_drain_occ",  32'(s.occ),       32'h0);
      chk("t1_drain_vld",  32'(s.out_valid), 32'h0);
      chk("t1_drain_ctrl", 32'(s.out_ctrl),  32'h0);
      chk("t1_drain_data", 32'(s.out_data),  32'h3);

      // 2) Backpressure fills the skid entry, then drains in order
      s.out_ready = 1'b0;
      drv_s(1'b1, 32'hA, 8'h2A);
      tick();
      chk("t2_occ1",      32'(s.occ),      32'h1);
      chk("t2_in_ready1", 32'(s.in_ready), 32'h1);
      drv_s(1'b1, 32'hB, 8'h2B);
      tick();
      chk("t2_occ2",     32'(s.occ),      32'h2);
      chk("t2_in_ready", 32'(s.in_ready), 32'h0);
      chk("t2_head",     32'(s.out_data), 32'hA);
      drv_s(1'b0, 32'h0, 8'h0);
      s.out_ready = 1'b1;
      settle();
      chk("t2_in_ready_comb", 32'(s.in_ready), 32'h0);
      tick();
      chk("t2_second",        32'(s.out_data), 32'hB);
      chk("t2_second_ctrl",   32'(s.out_ctrl), 32'h2B);
      chk("t2_in_ready_back", 32'(s.in_ready), 32'h1);
      chk("t2_occ_after",     32'(s.occ),      32'h1);
      tick();
      chk("t2_empty", 32'(s.occ), 32'h0);

      // 3) Flush while FULL drops both entries and the input offered that cycle
      s.out_ready = 1'b0;
      drv_s(1'b1, 32'hC, 8'h3C);
      tick();
      drv_s(1'b1, 32'hD, 8'h3D);
      tick();
      chk("t3_full", 32'(s.occ), 32'h2);
      drv_s(1'b1, 32'hE, 8'h3E);
      s.flush = 1'b1;
      tick();
      s.flush = 1'b0;
      drv_s(1'b0, 32'h0, 8'h0);
      chk("t3_occ",  32'(s.occ),       32'h0);
      chk("t3_vld",  32'(s.out_valid), 32'h0);
      chk("t3_ctrl", 32'(s.out_ctrl),  32'h0);
      chk("t3_drop", 32'(s.drop_cnt),  32'h2);
      chk("t3_data_hold", 32'(s.out_data), 32'hC);
      tick();
      chk("t3_input_lost", 32'(s.occ), 32'h0);

      // Flush at ONE with an accepted input: held entry counted, input discarded
      drv_s(1'b1, 32'h31, 8'h31);
      tick();
      drv_s(1'b1, 32'h32, 8'h32);
      s.flush = 1'b1;
      settle();
      chk("t3b_in_ready", 32'(s.in_ready), 32'h1);
      tick();
      s.flush = 1'b0;
      drv_s(1'b0, 32'h0, 8'h0);
      chk("t3b_occ",  32'(s.occ),      32'h0);
      chk("t3b_drop", 32'(s.drop_cnt), 32'h3);

      // 4) Flush with out_ready=1 at occ=1: entry completes, not counted
      drv_s(1'b1, 32'hF, 8'h4F);
      tick();
      drv_s(1'b0, 32'h0, 8'h0);
      s.out_ready = 1'b1;
      s.flush     = 1'b1;
      settle();
      chk("t4_vld_flush_cycle",  32'(s.out_valid), 32'h1);
      chk("t4_data_flush_cycle", 32'(s.out_data),  32'hF);
      tick();
      s.flush     = 1'b0;
      s.out_ready = 1'b0;
      chk("t4_drop_unchanged", 32'(s.drop_cnt), 32'h3);
      chk("t4_occ",            32'(s.occ),      32'h0);

      // Saturation: 300 single-entry flushes on top of 3
      for (int i = 0; i < 300; i++) begin
         drv_s(1'b1, 32'(i), 8'h55);
         tick();
         drv_s(1'b0, 32'h0, 8'h0);
         s.flush = 1'b1;
         tick();
         s.flush = 1'b0;
         if (i == 99) chk("t4_drop_mid", 32'(s.drop_cnt), 32'd103);
      end
      chk("t4_drop_sat", 32'(s.drop_cnt), 32'd255);

      // 5) Stall freezes both sides, entry delivered once on release
      drv_s(1'b1, 32'h77, 8'h57);
      tick();
      drv_s(1'b1, 32'h78, 8'h58);
      s.out_ready = 1'b1;
      s.stall     = 1'b1;
      settle();
      chk("t5_vld_stalled",   32'(s.out_valid), 32'h0);
      chk("t5_rdy_stalled",   32'(s.in_ready),  32'h0);
      chk("t5_ctrl_stalled",  32'(s.out_ctrl),  32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t5_occ_hold",  32'(s.occ),      32'h1);
         chk("t5_data_hold", 32'(s.out_data), 32'h77);
      end
      drv_s(1'b0, 32'h0, 8'h0);
      s.stall = 1'b0;
      settle();
      chk("t5_vld_release",  32'(s.out_valid), 32'h1);
      chk("t5_data_release", 32'(s.out_data),  32'h77);
      chk("t5_ctrl_release", 32'(s.out_ctrl),  32'h57);
      tick();
      chk("t5_delivered_once", 32'(s.occ),       32'h0);
      chk("t5_vld_after",      32'(s.out_valid), 32'h0);
      s.out_ready = 1'b0;

      // 6) Single-entry variant: combinational ready and pass-through
      n.out_ready = 1'b0;
      drv_n(1'b1, 32'h51, 8'h61);
      settle();
      chk("t6_rdy_empty", 32'(n.in_ready), 32'h1);
      tick();
      chk("t6_occ",         32'(n.occ),      32'h1);
      chk("t6_rdy_blocked", 32'(n.in_ready), 32'h0);
      chk("t6_head",        32'(n.out_data), 32'h51);
      n.out_ready = 1'b1;
      drv_n(1'b1, 32'h52, 8'h62);
      settle();
      chk("t6_rdy_comb", 32'(n.in_ready), 32'h1);
      tick();
      chk("t6_pass1", 32'(n.out_data), 32'h52);
      chk("t6_ctrl1", 32'(n.out_ctrl), 32'h62);
      chk("t6_occ1",  32'(n.occ),      32'h1);
      drv_n(1'b1, 32'h53, 8'h63);
      tick();
      chk("t6_pass2", 32'(n.out_data), 32'h53);
      chk("t6_drop",  32'(n.drop_cnt), 32'h0);

      // Asynchronous reset pulse mid-stream
      nRST = 1'b0;
      settle();
      chk("t6_rst_vld",  32'(n.out_valid), 32'h0);
      chk("t6_rst_data", 32'(n.out_data),  32'h0);
      chk("t6_rst_ctrl", 32'(n.out_ctrl),  32'h0);
      chk("t6_rst_occ",  32'(n.occ),       32'h0);
      chk("t6_rst_sdrop", 32'(s.drop_cnt), 32'h0);
      #2;
      nRST = 1'b1;
      drv_n(1'b0, 32'h0, 8'h0);
      tick();
      chk("t6_post_rst_occ", 32'(n.occ), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
